// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle event pulses into fixed-length,
// human-visible high windows separated by guaranteed low gaps. Events that
// arrive while a window or gap is running are counted in a saturating queue
// and replayed back-to-back.
module pulse_stretcher #(
    parameter int ON_CYCLES  = 7,
    parameter int OFF_CYCLES = 7,
    parameter int QUEUE_MAX  = 3
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_pulse,
    input  logic                           i_clear,
    output logic                           o_out,
    output logic                           o_busy,
    output logic [$clog2(QUEUE_MAX+1)-1:0] o_pending,
    output logic                           o_done,
    output logic                           o_overflow
);

    localparam int PEND_W = $clog2(QUEUE_MAX + 1);
    localparam int MAX_C  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    // With ON_CYCLES == OFF_CYCLES == 1 the natural width would be zero;
    // keep one bit so the counter stays a legal vector.
    localparam int CNT_W  = (MAX_C > 1) ? $clog2(MAX_C) : 1;

    localparam logic [CNT_W-1:0]  ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0]  OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] Q_FULL   = PEND_W'(QUEUE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [PEND_W-1:0]  pending;
    logic [PEND_W-1:0]  pend_nxt;
    logic               done_q;
    logic               ovf_q;
    logic               ovf_set;
    logic               final_off;
    logic               queue_req;

    // Last cycle of a gap: the only point where a queued event can be replayed.
    assign final_off = (state == OFF) && (cnt == '0);
    // A pulse that cannot start a window right now has to go into the queue.
    assign queue_req = i_pulse && ((state == ON) || ((state == OFF) && (cnt != '0)));

    // Next queue depth; a clear discards both the queue and any pulse that would join it.
    always_comb begin
        pend_nxt = pending;
        ovf_set  = 1'b0;
        if (i_clear) begin
            pend_nxt = '0;
        end else if (queue_req) begin
            if (pending == Q_FULL) begin
                ovf_set = 1'b1;
            end else begin
                pend_nxt = pending + 1'b1;
            end
        end else if (final_off && !i_pulse && (pending != '0)) begin
            // Replaying a queued event; a pulse in this cycle would instead
            // swap in for the dequeued one and leave the depth unchanged.
            pend_nxt = pending - 1'b1;
        end
    end

    // Window/gap sequencer with queue, done pulse and sticky overflow flag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            cnt     <= '0;
            pending <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            pending <= pend_nxt;
            if (i_clear) begin
                ovf_q <= 1'b0;
            end else if (ovf_set) begin
                ovf_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (i_pulse) begin
                        state <= ON;
                        cnt   <= ON_LOAD;
                    end
                end
                ON: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state  <= OFF;
                        cnt    <= OFF_LOAD;
                        done_q <= 1'b1;
                    end
                end
                OFF: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (i_pulse || ((pending != '0) && !i_clear)) begin
                        state <= ON;
                        cnt   <= ON_LOAD;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign o_out      = (state == ON);
    assign o_busy     = (state != IDLE);
    assign o_pending  = pending;
    assign o_done     = done_q;
    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Testbench for pulse_stretcher with ON_CYCLES=3, OFF_CYCLES=2, QUEUE_MAX=2.
// Each table row gives the inputs sampled at one edge and the outputs
// expected in the cycle after that edge.
module tb_pulse_stretcher;

    logic       clk;
    logic       rst;
    logic       pulse;
    logic       clear;
    logic       out;
    logic       busy;
    logic [1:0] pending;
    logic       done;
    logic       overflow;

    pulse_stretcher #(
        .ON_CYCLES (3),
        .OFF_CYCLES(2),
        .QUEUE_MAX (2)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_pulse   (pulse),
        .i_clear   (clear),
        .o_out     (out),
        .o_busy    (busy),
        .o_pending (pending),
        .o_done    (done),
        .o_overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // expected vector layout: {out, busy, done, pending[1:0], overflow}
    typedef struct {
        string    tag;
        int       step;
        logic     r;
        logic     c;
        logic     p;
        logic [5:0] exp;
    } vec_t;

    typedef struct {
        string      tag;
        int         step;
        logic [5:0] exp;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;
    string cur_tag = "";

    function automatic void begin_seq(input string tag);
        cur_tag = tag;
        step_no = 0;
    endfunction

    function automatic void add(input logic r, input logic c, input logic p,
                                input logic o, input logic b, input logic d,
                                input int pn, input logic ov);
        vec_t v;
        v.tag  = cur_tag;
        v.step = step_no;
        v.r    = r;
        v.c    = c;
        v.p    = p;
        v.exp  = {o, b, d, 2'(pn), ov};
        vecs.push_back(v);
        step_no++;
    endfunction

    // Append n quiet cycles that all expect the same outputs.
    function automatic void hold(input int n, input logic o, input logic b,
                                 input logic d, input int pn, input logic ov);
        for (int k = 0; k < n; k++) add(0, 0, 0, o, b, d, pn, ov);
    endfunction

    task automatic compare_one();
        sb_t        e;
        logic [5:0] act;
        e   = sb.pop_front();
        act = {out, busy, done, pending, overflow};
        checks++;
        if (act !== e.exp) begin
            failures++;
            $display("FAIL %s step %0d: got out/busy/done/pend/ovf=%b_%b_%b_%0d_%b expected %b_%b_%b_%0d_%b",
                     e.tag, e.step, act[5], act[4], act[3], act[2:1], act[0],
                     e.exp[5], e.exp[4], e.exp[3], e.exp[2:1], e.exp[0]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        pulse = 1'b0;
        clear = 1'b0;

        // reset state
        begin_seq("reset");
        add(1, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 0, 0);

        // single pulse: window cycles 1-3, done cycle 4, busy through 5
        begin_seq("single");
        add(0, 0, 1, 1, 1, 0, 0, 0);
        hold(2, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0);
        hold(2, 0, 0, 0, 0, 0);

        // three pulses: queued and replayed
        begin_seq("three");
        add(0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 1, 0);
        add(0, 0, 1, 1, 1, 0, 2, 0);
        add(0, 0, 0, 0, 1, 1, 2, 0);
        add(0, 0, 0, 0, 1, 0, 2, 0);
        hold(3, 1, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 1, 0);
        hold(3, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0);
        hold(1, 0, 0, 0, 0, 0);

        // four pulses: the fourth overflows; overflow sticks until clear
        begin_seq("overflow");
        add(0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 1, 0);
        add(0, 0, 1, 1, 1, 0, 2, 0);
        add(0, 0, 1, 0, 1, 1, 2, 1);
        add(0, 0, 0, 0, 1, 0, 2, 1);
        hold(3, 1, 1, 0, 1, 1);
        add(0, 0, 0, 0, 1, 1, 1, 1);
        add(0, 0, 0, 0, 1, 0, 1, 1);
        hold(3, 1, 1, 0, 0, 1);
        add(0, 0, 0, 0, 1, 1, 0, 1);
        add(0, 0, 0, 0, 1, 0, 0, 1);
        hold(2, 0, 0, 0, 0, 1);
        add(0, 1, 0, 0, 0, 0, 0, 0);

        // pulse exactly in the final gap cycle is consumed directly
        begin_seq("final_direct");
        add(0, 0, 1, 1, 1, 0, 0, 0);
        hold(2, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0);
        hold(2, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0);
        hold(1, 0, 0, 0, 0, 0);

        // pulse in final gap cycle with a non-empty queue swaps in
        begin_seq("final_swap");
        add(0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 1, 0);
        add(0, 0, 0, 1, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 1, 0);
        add(0, 0, 1, 1, 1, 0, 1, 0);
        hold(2, 1, 1, 0, 1, 0);
        add(0, 0, 0, 0, 1, 1, 1, 0);
        add(0, 0, 0, 0, 1, 0, 1, 0);
        hold(3, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0);
        hold(1, 0, 0, 0, 0, 0);

        // clear mid-window: queue dropped, window and gap still complete
        begin_seq("clear");
        add(0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 1, 0);
        add(0, 0, 1, 1, 1, 0, 2, 0);
        add(0, 1, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0);
        hold(2, 0, 0, 0, 0, 0);

        // clear with pulse: starts from idle, dropped silently when it would queue
        begin_seq("clear_pulse");
        add(0, 1, 1, 1, 1, 0, 0, 0);
        add(0, 1, 1, 1, 1, 0, 0, 0);
        add(0, 0, 0, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0);
        hold(1, 0, 0, 0, 0, 0);

        // reset mid-window: nothing replayed, fresh pulse works normally
        begin_seq("mid_reset");
        add(0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 1, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        hold(2, 0, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 0, 0);
        hold(2, 1, 1, 0, 0, 0);
        add(0, 0, 0, 0, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0, 0, 0);
        hold(2, 0, 0, 0, 0, 0);

        // reset during the gap with a full queue and overflow set
        begin_seq("gap_reset");
        add(0, 0, 1, 1, 1, 0, 0, 0);
        add(0, 0, 1, 1, 1, 0, 1, 0);
        add(0, 0, 1, 1, 1, 0, 2, 0);
        add(0, 0, 1, 0, 1, 1, 2, 1);
        add(1, 0, 0, 0, 0, 0, 0, 0);
        hold(3, 0, 0, 0, 0, 0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            sb_t s;
            rst   = vecs[i].r;
            clear = vecs[i].c;
            pulse = vecs[i].p;
            s.tag  = vecs[i].tag;
            s.step = vecs[i].step;
            s.exp  = vecs[i].exp;
            sb.push_back(s);
            @(posedge clk);
            #1;
            compare_one();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
